// File: rtl/ibex_counter_reader.sv
// Tear-free 32-bit read port for a 64-bit counter: a low read latches the high half as a shadow.
// Optional IBEX_COUNTER_READER_STATS_EN adds stale_cnt_o, a saturating count of stale high reads.
module ibex_counter_reader #(
  parameter int unsigned CounterWidth  = 64,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] counter_val_i,
  input  logic        counter_we_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_hi_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_stale_o
`ifdef IBEX_COUNTER_READER_STATS_EN
  ,
  output logic [15:0] stale_cnt_o
`endif
);

  localparam logic [63:0] CounterMask = {64{1'b1}} >> (64 - CounterWidth);
  localparam logic [7:0]  TimerInit   = 8'(TimeoutCycles - 1);

  typedef enum logic {
    IDLE,
    SHADOW
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] shadow_q, shadow_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_stale_q, rsp_stale_d;

  logic [63:0] masked;
  logic        req_accept;

  assign masked      = counter_val_i & CounterMask;
  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;

  // An accepted read always wins over timeout and write invalidation in the same cycle.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    shadow_d    = shadow_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_stale_d = rsp_stale_q;
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      if (!req_hi_i) begin
        rsp_data_d  = masked[31:0];
        rsp_stale_d = 1'b0;
        shadow_d    = masked[63:32];
        timer_d     = TimerInit;
        state_d     = counter_we_i ? IDLE : SHADOW;
      end else if (state_q == SHADOW) begin
        rsp_data_d  = shadow_q;
        rsp_stale_d = 1'b0;
        state_d     = IDLE;
      end else begin
        rsp_data_d  = masked[63:32];
        rsp_stale_d = 1'b1;
      end
    end else begin
      if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
      end
      if (state_q == SHADOW) begin
        if (counter_we_i || timer_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      timer_q     <= 8'd0;
      shadow_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_stale_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      shadow_q    <= shadow_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_stale_q <= rsp_stale_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_stale_o = rsp_stale_q;

`ifdef IBEX_COUNTER_READER_STATS_EN
  logic [15:0] stale_cnt_q, stale_cnt_d;
  logic        stale_hit;

  assign stale_hit = req_accept && req_hi_i && (state_q == IDLE);

  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (stale_hit && stale_cnt_q != 16'hFFFF) begin
      stale_cnt_d = stale_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stale_cnt_q <= 16'd0;
    end else begin
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign stale_cnt_o = stale_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_counter_reader.sv
// Self-checking bench for ibex_counter_reader: two instances (64-bit/T=4 and 40-bit/T=7) share stimulus
// and are compared every cycle against a deadline-based reference model; honours IBEX_COUNTER_READER_STATS_EN.
module tb_ibex_counter_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] counter_val;
  logic        counter_we;
  logic        req_valid;
  logic        req_hi;
  logic        rsp_ready;

  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_stale;
  logic [31:0] rsp_data [2];
`ifdef IBEX_COUNTER_READER_STATS_EN
  logic [15:0] stale_cnt [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_counter_reader #(.CounterWidth(64), .TimeoutCycles(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .counter_val_i(counter_val), .counter_we_i(counter_we),
    .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_hi_i(req_hi),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[0]),
    .rsp_stale_o(rsp_stale[0])
`ifdef IBEX_COUNTER_READER_STATS_EN
    , .stale_cnt_o(stale_cnt[0])
`endif
  );

  ibex_counter_reader #(.CounterWidth(40), .TimeoutCycles(7)) dut1 (
    .clk_i(clk), .rst_i(rst), .counter_val_i(counter_val), .counter_we_i(counter_we),
    .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_hi_i(req_hi),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[1]),
    .rsp_stale_o(rsp_stale[1])
`ifdef IBEX_COUNTER_READER_STATS_EN
    , .stale_cnt_o(stale_cnt[1])
`endif
  );

  // Reference model: a shadow is usable for high reads up to and including cycle (low cycle + timeout).
  logic        exp_valid [2];
  logic [31:0] exp_data [2];
  logic        exp_stale [2];
  logic        sh_valid [2];
  logic [31:0] sh_val [2];
  int          sh_deadline [2];
  int          exp_cnt [2];
  int          cyc = 0;
  logic        was_reset = 1'b0;

  function automatic int width_of(input int i);
    return (i == 0) ? 64 : 40;
  endfunction

  function automatic int timeout_of(input int i);
    return (i == 0) ? 4 : 7;
  endfunction

  function automatic logic [63:0] masked_of(input logic [63:0] v, input int cw);
    if (cw >= 64) return v;
    return v & ((64'd1 << cw) - 64'd1);
  endfunction

  task automatic model_edge();
    logic [63:0] m;
    logic        acc;
    for (int i = 0; i < 2; i++) begin
      m = masked_of(counter_val, width_of(i));
      if (rst) begin
        exp_valid[i] = 1'b0;
        exp_data[i]  = 32'd0;
        exp_stale[i] = 1'b0;
        sh_valid[i]  = 1'b0;
        exp_cnt[i]   = 0;
      end else begin
        acc = req_valid && (!exp_valid[i] || rsp_ready);
        if (acc) begin
          exp_valid[i] = 1'b1;
          if (!req_hi) begin
            exp_data[i]    = m[31:0];
            exp_stale[i]   = 1'b0;
            sh_val[i]      = m[63:32];
            sh_valid[i]    = 1'b1;
            sh_deadline[i] = cyc + timeout_of(i);
          end else if (sh_valid[i] && cyc <= sh_deadline[i]) begin
            exp_data[i]  = sh_val[i];
            exp_stale[i] = 1'b0;
            sh_valid[i]  = 1'b0;
          end else begin
            exp_data[i]  = m[63:32];
            exp_stale[i] = 1'b1;
            sh_valid[i]  = 1'b0;
            if (exp_cnt[i] < 65535) exp_cnt[i]++;
          end
        end else if (rsp_ready) begin
          exp_valid[i] = 1'b0;
        end
        if (counter_we) sh_valid[i] = 1'b0;
      end
    end
    was_reset = rst;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [63:0] v, input logic we,
                                input logic rv, input logic hi, input logic rr);
    @(negedge clk);
    rst = r; counter_val = v; counter_we = we; req_valid = rv; req_hi = hi; rsp_ready = rr;
    #1;
    for (int i = 0; i < 2; i++)
      check_output($sformatf("d%0d_req_ready@%0d", i, cyc), {31'd0, req_ready[i]},
                   {31'd0, !exp_valid[i] || rr});
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("d%0d_rsp_valid@%0d", i, cyc), {31'd0, rsp_valid[i]}, {31'd0, exp_valid[i]});
      if (exp_valid[i] || was_reset) begin
        check_output($sformatf("d%0d_rsp_data@%0d", i, cyc), rsp_data[i], exp_data[i]);
        check_output($sformatf("d%0d_rsp_stale@%0d", i, cyc), {31'd0, rsp_stale[i]}, {31'd0, exp_stale[i]});
      end
`ifdef IBEX_COUNTER_READER_STATS_EN
      check_output($sformatf("d%0d_stale_cnt@%0d", i, cyc), {16'd0, stale_cnt[i]}, 32'(exp_cnt[i]));
`endif
    end
  endtask

  task automatic idle(input int n, input logic [63:0] v);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, v, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [63:0] rv;
    rst = 1'b1; counter_val = '0; counter_we = 1'b0; req_valid = 1'b0; req_hi = 1'b0; rsp_ready = 1'b1;
    $display("[TB] reset");
    apply_stimulus(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("reset_ready", {31'd0, req_ready[0]}, 32'd1);

    $display("[TB] low-then-high read");
    apply_stimulus(1'b0, 64'h0000_0001_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    check_output("s1_lo_data", rsp_data[0], 32'hFFFF_FFFF);
    idle(2, 64'h0000_0002_0000_0003);
    apply_stimulus(1'b0, 64'h0000_0002_0000_0003, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s1_hi_data", rsp_data[0], 32'h0000_0001);
    check_output("s1_hi_stale", {31'd0, rsp_stale[0]}, 32'd0);
    idle(6, 64'h0000_0002_0000_0003);

    $display("[TB] high read without shadow");
    apply_stimulus(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s2_data", rsp_data[0], 32'h1234_5678);
    check_output("s2_stale", {31'd0, rsp_stale[0]}, 32'd1);
    check_output("s2_data_w40", rsp_data[1], 32'h0000_0078);

    $display("[TB] timeout");
    apply_stimulus(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(5, 64'h5555_0000_0000_0000);
    apply_stimulus(1'b0, 64'h5555_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s3_late_data", rsp_data[0], 32'h5555_0000);
    check_output("s3_late_stale", {31'd0, rsp_stale[0]}, 32'd1);
    apply_stimulus(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 64'h5555_0000_0000_0000);
    apply_stimulus(1'b0, 64'h5555_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s3_edge_data", rsp_data[0], 32'h1234_5678);
    check_output("s3_edge_stale", {31'd0, rsp_stale[0]}, 32'd0);

    $display("[TB] backpressure");
    apply_stimulus(1'b0, 64'h0BAD_CAFE_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b0, 64'h0BAD_CAFE_9ABC_DEF0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_output("s4_hold_data", rsp_data[0], 32'h9ABC_DEF0);
      check_output("s4_hold_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    apply_stimulus(1'b0, 64'h0BAD_CAFE_9ABC_DEF0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s4_hi_w40", rsp_data[1], 32'h0000_00FE);
    idle(1, 64'h0BAD_CAFE_9ABC_DEF0);

    $display("[TB] write invalidation");
    apply_stimulus(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 64'hAAAA_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 64'hAAAA_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s5_data", rsp_data[0], 32'hAAAA_0000);
    check_output("s5_stale", {31'd0, rsp_stale[0]}, 32'd1);

    $display("[TB] reset mid-transaction");
    idle(1, 64'h1234_5678_9ABC_DEF0);
    apply_stimulus(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("s6_valid", {31'd0, rsp_valid[0]}, 32'd0);
    apply_stimulus(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s6_stale", {31'd0, rsp_stale[0]}, 32'd1);

    $display("[TB] randomized traffic");
    rv = 64'h0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(3) == 0) rv = {$urandom, $urandom};
      apply_stimulus($urandom_range(63) == 0, rv, $urandom_range(7) == 0,
                     $urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
